// File: rtl/ltc2175_frame_align.sv
`timescale 1ns/1ps
// LTC2175 frame-lane word aligner: pulses ISERDES2 BITSLIP until the frame word matches PATTERN,
// then monitors lock. Define FRAME_ERR_CNT_EN to build the LOCKED-state frame-error counter.
module ltc2175_frame_align #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] PATTERN     = 8'hF0,
  parameter int               SETTLE      = 7,
  parameter int               MATCH_CNT   = 16,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       frame_data,
  output logic                   bitslip,
  output logic                   aligned,
  output logic                   fail,
  output logic [$clog2(WIDTH):0] slip_cnt,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int SLIP_W  = $clog2(WIDTH) + 1;
  localparam int SET_W   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int MATCH_W = (MATCH_CNT > 1) ? $clog2(MATCH_CNT + 1) : 1;
  localparam int LOSS_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  typedef enum logic [2:0] {
    ST_SETTLE_WAIT = 3'd0,
    ST_CHECK       = 3'd1,
    ST_SLIP        = 3'd2,
    ST_LOCKED      = 3'd3,
    ST_FAIL        = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [SET_W-1:0]    settle_cnt_r;
  logic [MATCH_W-1:0]  match_cnt_r;
  logic [LOSS_W-1:0]   loss_cnt_r;
  logic [SLIP_W-1:0]   slip_cnt_r;
  logic                bitslip_r;
  logic                aligned_r;
  logic                fail_r;
  logic                bitslip_s;
  logic                aligned_s;
  logic                fail_s;
  logic                word_match_s;
  logic                settle_done_s;
  logic                match_done_s;
  logic                loss_done_s;
  logic                slips_exhausted_s;

  assign word_match_s      = (frame_data == PATTERN);
  assign settle_done_s     = (settle_cnt_r == SET_W'(SETTLE - 1));
  assign match_done_s      = (match_cnt_r == MATCH_W'(MATCH_CNT - 1));
  assign loss_done_s       = (loss_cnt_r == LOSS_W'(LOSS_THRESH - 1));
  assign slips_exhausted_s = (slip_cnt_r == SLIP_W'(WIDTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SETTLE_WAIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; start overrides every state
  always_comb begin
    next_state_s = state_r;
    if (start) begin
      next_state_s = ST_SETTLE_WAIT;
    end else begin
      case (state_r)
        ST_SETTLE_WAIT: begin
          if (settle_done_s) next_state_s = ST_CHECK;
          else               next_state_s = ST_SETTLE_WAIT;
        end
        ST_CHECK: begin
          if (word_match_s) begin
            if (match_done_s) next_state_s = ST_LOCKED;
            else              next_state_s = ST_CHECK;
          end else if (slips_exhausted_s) begin
            next_state_s = ST_FAIL;
          end else begin
            next_state_s = ST_SLIP;
          end
        end
        ST_SLIP:   next_state_s = ST_SETTLE_WAIT;
        ST_LOCKED: begin
          // Loss of lock retries the current alignment before slipping again
          if (!word_match_s && loss_done_s) next_state_s = ST_CHECK;
          else                              next_state_s = ST_LOCKED;
        end
        ST_FAIL:   next_state_s = ST_FAIL;
        default:   next_state_s = ST_SETTLE_WAIT;
      endcase
    end
  end

  // Output decode from the transition, so each flop reflects the state being entered
  always_comb begin
    bitslip_s = (next_state_s == ST_SLIP);
    aligned_s = (state_r == ST_LOCKED) && (next_state_s == ST_LOCKED);
    fail_s    = (next_state_s == ST_FAIL);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bitslip_r <= 1'b0;
      aligned_r <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      bitslip_r <= bitslip_s;
      aligned_r <= aligned_s;
      fail_r    <= fail_s;
    end
  end

  // Settle timer: runs only while staying in SETTLE_WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= '0;
    end else if (!start && (state_r == ST_SETTLE_WAIT) && (next_state_s == ST_SETTLE_WAIT)) begin
      settle_cnt_r <= settle_cnt_r + SET_W'(1);
    end else begin
      settle_cnt_r <= '0;
    end
  end

  // Consecutive-match counter; never exceeds MATCH_CNT-1 because lock is taken at that value
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_r <= '0;
    end else if (!start && (state_r == ST_CHECK) && (next_state_s == ST_CHECK)) begin
      match_cnt_r <= match_cnt_r + MATCH_W'(1);
    end else begin
      match_cnt_r <= '0;
    end
  end

  // Consecutive-mismatch counter while locked
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_r <= '0;
    end else if (!start && (state_r == ST_LOCKED) && (next_state_s == ST_LOCKED) && !word_match_s) begin
      loss_cnt_r <= loss_cnt_r + LOSS_W'(1);
    end else begin
      loss_cnt_r <= '0;
    end
  end

  // Bitslip tally since the last restart or loss of lock
  always_ff @(posedge clk) begin
    if (rst) begin
      slip_cnt_r <= '0;
    end else if (start) begin
      slip_cnt_r <= '0;
    end else if (state_r == ST_SLIP) begin
      slip_cnt_r <= slip_cnt_r + SLIP_W'(1);
    end else if ((state_r == ST_LOCKED) && (next_state_s == ST_CHECK)) begin
      slip_cnt_r <= '0;
    end else begin
      slip_cnt_r <= slip_cnt_r;
    end
  end

`ifdef FRAME_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_r;

  // Saturating count of bad frame words seen while locked; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= '0;
    end else if (!start && (state_r == ST_LOCKED) && !word_match_s && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = '0;
`endif

  assign bitslip  = bitslip_r;
  assign aligned  = aligned_r;
  assign fail     = fail_r;
  assign slip_cnt = slip_cnt_r;

endmodule

// File: tb/tb_ltc2175_frame_align.sv
`timescale 1ns/1ps
// Scoreboard bench for ltc2175_frame_align: expected output values are queued with the cycle
// they are due and compared on the falling edge of that cycle.
module tb_ltc2175_frame_align;

  localparam int SETTLE    = 7;
  localparam int MATCH_CNT = 16;
  localparam int LOCK_REL  = SETTLE + MATCH_CNT + 1;
  localparam int SLIP_REL  = SETTLE + 1;
  localparam int SLIP_PER  = SETTLE + 2;
`ifdef FRAME_ERR_CNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  localparam int S_BS = 0, S_AL = 1, S_FL = 2, S_SC = 3, S_EC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  frame_data;
  logic        bitslip;
  logic        aligned;
  logic        fail;
  logic [3:0]  slip_cnt;
  logic [15:0] err_cnt;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   nslips    = 0;
  int   last_slip = -1;
  int   min_gap   = 100000;
  bit   rot_mode  = 1'b0;
  int   slip_base = 0;

  ltc2175_frame_align dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_data (frame_data),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .fail       (fail),
    .slip_cnt   (slip_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_BS:    return 32'(bitslip);
      S_AL:    return 32'(aligned);
      S_FL:    return 32'(fail);
      S_SC:    return 32'(slip_cnt);
      S_EC:    return 32'(err_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << (n & 7);
    return d[15:8];
  endfunction

  task automatic push(input int at, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.cyc = at;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Scoreboard: compare every entry that has come due
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        check_eq(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  // Bitslip tally and closest spacing between pulses
  always @(negedge clk) begin
    if (bitslip === 1'b1) begin
      if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      nslips++;
    end
  end

  // Source model: word rotated left by 3, each observed bitslip rotates it back one bit
  task automatic tick();
    @(posedge clk);
    #1;
    if (rot_mode) frame_data = rotl8(8'hF0, 3 - (nslips - slip_base));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    push(cyc, S_BS, 32'd0, "rst_bitslip");
    push(cyc, S_AL, 32'd0, "rst_aligned");
    push(cyc, S_FL, 32'd0, "rst_fail");
    push(cyc, S_SC, 32'd0, "rst_slip_cnt");
    push(cyc, S_EC, 32'd0, "rst_err_cnt");
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int s0;
    rst        = 1'b1;
    start      = 1'b0;
    frame_data = 8'hF0;

    // Already aligned: lock with no bitslip
    do_reset();
    b  = cyc;
    s0 = nslips;
    push(b + LOCK_REL - 1, S_AL, 32'd0, "a_aligned_early");
    push(b + LOCK_REL,     S_AL, 32'd1, "a_aligned");
    push(b + LOCK_REL,     S_SC, 32'd0, "a_slip_cnt");
    repeat (30) tick();

    // Three bad words: lock held, errors counted
    b = cyc;
    for (int k = 1; k <= 6; k++) push(b + k, S_AL, 32'd1, "b_aligned");
    push(b + 5, S_EC, 32'(3 * ERR_ON), "b_err_cnt");
    frame_data = 8'h0F;
    repeat (3) tick();
    frame_data = 8'hF0;
    repeat (5) tick();

    // Four bad words: lock lost, regained after MATCH_CNT good words, no slip
    b = cyc;
    push(b + 3,                 S_AL, 32'd1, "c_aligned_hold");
    push(b + 4,                 S_AL, 32'd0, "c_aligned_drop");
    push(b + 4 + MATCH_CNT,     S_AL, 32'd0, "c_aligned_early");
    push(b + 4 + MATCH_CNT + 1, S_AL, 32'd1, "c_aligned_back");
    push(b + 4 + MATCH_CNT + 1, S_SC, 32'd0, "c_slip_cnt");
    push(b + 4 + MATCH_CNT + 1, S_EC, 32'(7 * ERR_ON), "c_err_cnt");
    frame_data = 8'h0F;
    repeat (4) tick();
    frame_data = 8'hF0;
    repeat (20) tick();
    check_eq("ac_no_bitslip", 32'(nslips - s0), 32'd0);

    // start keeps err_cnt; rst on the bitslip cycle clears everything
    frame_data = 8'hAA;
    b = cyc;
    push(b + 1,            S_AL, 32'd0, "f_aligned_start");
    push(b + 1,            S_EC, 32'(7 * ERR_ON), "f_err_kept");
    push(b + 1 + SLIP_REL - 1, S_BS, 32'd0, "f_bitslip_early");
    push(b + 1 + SLIP_REL, S_BS, 32'd1, "f_bitslip");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SLIP_REL) tick();
    rst = 1'b1;
    push(cyc + 1, S_BS, 32'd0, "f_rst_bitslip");
    push(cyc + 1, S_SC, 32'd0, "f_rst_slip_cnt");
    push(cyc + 1, S_EC, 32'd0, "f_rst_err_cnt");
    push(cyc + 1, S_AL, 32'd0, "f_rst_aligned");
    push(cyc + 1, S_FL, 32'd0, "f_rst_fail");
    tick();

    // Rotated source: three slips, then lock
    slip_base = nslips;
    rot_mode  = 1'b1;
    do_reset();
    b = cyc;
    push(b + SLIP_REL - 1,            S_BS, 32'd0, "r_bitslip_early");
    push(b + SLIP_REL,                S_BS, 32'd1, "r_bitslip1");
    push(b + SLIP_REL,                S_SC, 32'd0, "r_slip_cnt0");
    push(b + SLIP_REL + 1,            S_BS, 32'd0, "r_bitslip1_end");
    push(b + SLIP_REL + 1,            S_SC, 32'd1, "r_slip_cnt1");
    push(b + SLIP_REL + SLIP_PER,     S_BS, 32'd1, "r_bitslip2");
    push(b + SLIP_REL + 2 * SLIP_PER, S_BS, 32'd1, "r_bitslip3");
    push(b + SLIP_REL + 2 * SLIP_PER + LOCK_REL, S_AL, 32'd0, "r_aligned_early");
    push(b + SLIP_REL + 2 * SLIP_PER + LOCK_REL + 1, S_AL, 32'd1, "r_aligned");
    push(b + SLIP_REL + 2 * SLIP_PER + LOCK_REL + 1, S_SC, 32'd3, "r_slip_cnt3");
    push(b + SLIP_REL + 2 * SLIP_PER + LOCK_REL + 1, S_FL, 32'd0, "r_fail");
    repeat (60) tick();
    check_eq("r_nslips", 32'(nslips - slip_base), 32'd3);
    rot_mode = 1'b0;

    // No lock possible: eight slips then fail; start restarts; start during a slip
    frame_data = 8'hAA;
    s0 = nslips;
    do_reset();
    b = cyc;
    push(b + SLIP_REL + 7 * SLIP_PER,            S_BS, 32'd1, "n_bitslip8");
    push(b + SLIP_REL + 7 * SLIP_PER + SLIP_PER - 1, S_FL, 32'd0, "n_fail_early");
    push(b + SLIP_REL + 8 * SLIP_PER,            S_FL, 32'd1, "n_fail");
    push(b + SLIP_REL + 8 * SLIP_PER,            S_BS, 32'd0, "n_no_9th_slip");
    push(b + SLIP_REL + 8 * SLIP_PER,            S_SC, 32'd8, "n_slip_cnt8");
    push(b + SLIP_REL + 8 * SLIP_PER,            S_AL, 32'd0, "n_aligned");
    repeat (SLIP_REL + 8 * SLIP_PER + 5) tick();
    check_eq("n_nslips", 32'(nslips - s0), 32'd8);
    b = cyc;
    push(b,                           S_FL, 32'd1, "n_fail_held");
    push(b + 1,                       S_FL, 32'd0, "n_fail_cleared");
    push(b + 1,                       S_SC, 32'd0, "n_slip_cleared");
    push(b + 1 + SLIP_REL,            S_BS, 32'd1, "n_restart_slip1");
    push(b + 2 + SLIP_REL,            S_SC, 32'd1, "n_restart_cnt1");
    push(b + 1 + SLIP_REL + SLIP_PER, S_BS, 32'd1, "n_restart_slip2");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SLIP_REL + SLIP_PER) tick();
    start = 1'b1;
    push(cyc + 1,            S_SC, 32'd0, "n_start_in_slip_cnt");
    push(cyc + 1,            S_BS, 32'd0, "n_start_in_slip_bs");
    push(cyc + 1 + SLIP_REL, S_BS, 32'd1, "n_start_in_slip_next");
    tick();
    start = 1'b0;
    repeat (SLIP_REL + 3) tick();

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) tick();
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    check_eq("slip_spacing_ok", 32'(min_gap >= SETTLE + 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
